// File: rtl/vppm_rx_pkg.sv
// rtl/vppm_rx_pkg.sv - shared types and constants for the VPPM frame receiver
package vppm_rx_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CHECK
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CSUM    = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT = 3'd3;
  localparam logic [2:0] ERR_OVF     = 3'd4;

endpackage

// File: rtl/vppm_bit_deserializer.sv
// rtl/vppm_bit_deserializer.sv - MSB-first bit shifter with byte counter and sync clear
module vppm_bit_deserializer
  import vppm_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_shift,
  input  logic              i_bit,
  input  logic              i_count_en,
  input  logic              i_clear,
  output logic [BYTE_W-1:0] o_window,
  output logic              o_byte_done
);

  logic [BYTE_W-1:0] r_sr;
  logic [2:0]        r_cnt;

  // Window includes the bit arriving this cycle so sync/byte decisions need no extra latency.
  assign o_window    = {r_sr[BYTE_W-2:0], i_bit};
  assign o_byte_done = i_shift & i_count_en & (r_cnt == 3'd7);

  // Shift on every accepted bit; count only while deframing; clear beats a same-cycle bit.
  always_ff @(posedge clk) begin
    if (!rst_n || i_clear) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_shift) begin
      r_sr <= o_window;
      if (i_count_en) begin
        r_cnt <= r_cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/vppm_frame_receiver.sv
// rtl/vppm_frame_receiver.sv - sync hunt, LEN/payload/checksum deframing and byte output port
module vppm_frame_receiver
  import vppm_rx_pkg::*;
#(
  parameter logic [7:0]  SYNC_WORD      = 8'hA7,
  parameter int          MAX_LEN        = 32,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_active,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic [7:0]  r_remaining;
  logic [7:0]  r_csum;
  logic [31:0] r_idle;
  logic [7:0]  r_out_data;
  logic        r_out_valid;
  logic        r_frame_active;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic [2:0]  r_err_code;
  logic        w_timeout;
  logic        w_sync;
  logic        w_len_ok;
  logic        w_load;
  logic        w_ok;
  logic        w_err;
  logic [2:0]  w_err_code;
  logic        w_clear;

  vppm_bit_deserializer u_deser (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_shift    (bit_valid),
    .i_bit      (bit_in),
    .i_count_en (r_state != HUNT),
    .i_clear    (w_clear),
    .o_window   (w_byte),
    .o_byte_done(w_byte_done)
  );

  // A strobe in the expiry cycle keeps the frame alive, hence the ~bit_valid term.
  assign w_timeout = (r_state != HUNT) && !bit_valid && (r_idle == TIMEOUT_CYCLES - 32'd1);
  assign w_clear   = w_sync | w_ok | w_err;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle frame events.
  always_comb begin
    w_state_nxt = r_state;
    w_sync      = 1'b0;
    w_len_ok    = 1'b0;
    w_load      = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    w_err_code  = ERR_NONE;
    if (w_timeout) begin
      w_err       = 1'b1;
      w_err_code  = ERR_TIMEOUT;
      w_state_nxt = HUNT;
    end else begin
      case (r_state)
        HUNT: begin
          if (bit_valid && (w_byte == SYNC_WORD)) begin
            w_sync      = 1'b1;
            w_state_nxt = LEN;
          end
        end
        LEN: begin
          if (w_byte_done) begin
            if ((w_byte == 8'd0) || (w_byte > MAX_LEN_B)) begin
              w_err       = 1'b1;
              w_err_code  = ERR_LEN;
              w_state_nxt = HUNT;
            end else begin
              w_len_ok    = 1'b1;
              w_state_nxt = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (w_byte_done) begin
            if (r_out_valid && !out_ready) begin
              w_err       = 1'b1;
              w_err_code  = ERR_OVF;
              w_state_nxt = HUNT;
            end else begin
              w_load = 1'b1;
              if (r_remaining == 8'd1) begin
                w_state_nxt = CHECK;
              end
            end
          end
        end
        CHECK: begin
          if (w_byte_done) begin
            if (w_byte == r_csum) begin
              w_ok = 1'b1;
            end else begin
              w_err      = 1'b1;
              w_err_code = ERR_CSUM;
            end
            w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Datapath: idle counter, length/checksum tracking, status pulses and output byte register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idle         <= '0;
      r_remaining    <= '0;
      r_csum         <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_frame_active <= 1'b0;
      r_frame_ok     <= 1'b0;
      r_frame_err    <= 1'b0;
      r_err_code     <= ERR_NONE;
    end else begin
      r_idle      <= ((w_state_nxt == HUNT) || bit_valid) ? 32'd0 : r_idle + 32'd1;
      r_frame_ok  <= w_ok;
      r_frame_err <= w_err;
      if (w_sync) begin
        r_frame_active <= 1'b1;
        r_err_code     <= ERR_NONE;
      end else if (w_ok || w_err) begin
        r_frame_active <= 1'b0;
        if (w_err) begin
          r_err_code <= w_err_code;
        end
      end
      if (w_len_ok) begin
        r_remaining <= w_byte;
        r_csum      <= w_byte;
      end else if (w_load) begin
        r_remaining <= r_remaining - 8'd1;
        r_csum      <= r_csum ^ w_byte;
      end
      if (w_load) begin
        r_out_data  <= w_byte;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_valid    = r_out_valid;
  assign frame_active = r_frame_active;
  assign frame_ok     = r_frame_ok;
  assign frame_err    = r_frame_err;
  assign err_code     = r_err_code;

endmodule

// File: tb/tb_vppm_frame_receiver.sv
// tb/tb_vppm_frame_receiver.sv - self-checking bench for vppm_frame_receiver
module tb_vppm_frame_receiver;

  localparam int MAXL = 32;
  localparam int TMO  = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       frame_active;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         ok_cnt = 0;
  int         err_cnt = 0;
  logic [2:0] last_err = 3'd0;
  bit         both_seen = 1'b0;
  bit         active_seen = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] pq[$];

  vppm_frame_receiver #(
    .SYNC_WORD     (8'hA7),
    .MAX_LEN       (MAXL),
    .TIMEOUT_CYCLES(32'(TMO))
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .frame_active(frame_active),
    .frame_ok    (frame_ok),
    .frame_err   (frame_err),
    .err_code    (err_code)
  );

  initial begin
    forever #5 clk = ~clk;
  end

  initial begin
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) got_q.push_back(out_data);
        if (frame_ok) ok_cnt++;
        if (frame_err) begin
          err_cnt++;
          last_err = err_code;
        end
        if (frame_ok && frame_err) both_seen = 1'b1;
        if (frame_active) active_seen = 1'b1;
      end
    join_none
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    got_q.delete();
    exp_q.delete();
    ok_cnt = 0;
    err_cnt = 0;
    both_seen = 1'b0;
    active_seen = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int maxgap);
    int gap;
    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    bit_valid = 1'b0;
    idle(gap);
    bit_valid = 1'b1;
    bit_in = b;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    bit_in = 1'($urandom_range(1, 0));
  endtask

  task automatic send_byte(input logic [7:0] v, input int maxgap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], maxgap);
  endtask

  // Reference: what a frame with this LEN/payload/checksum must produce at the byte port and status.
  task automatic model_frame(input logic [7:0] len, input logic [7:0] pay[$], input logic [7:0] cs,
                             output int e_ok, output int e_err, output logic [2:0] e_code);
    logic [7:0] x;
    e_ok = 0;
    e_err = 0;
    e_code = 3'd0;
    if (len == 8'd0 || int'(len) > MAXL) begin
      e_err = 1;
      e_code = 3'd2;
    end else begin
      x = len;
      foreach (pay[i]) begin
        exp_q.push_back(pay[i]);
        x = x ^ pay[i];
      end
      if (x == cs) e_ok = 1;
      else begin
        e_err = 1;
        e_code = 3'd1;
      end
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] len, input logic [7:0] pay[$],
                           input logic [7:0] cs, input int maxgap);
    int         e_ok;
    int         e_err;
    logic [2:0] e_code;
    clear_stats();
    model_frame(len, pay, cs, e_ok, e_err, e_code);
    send_byte(8'hA7, maxgap);
    send_byte(len, maxgap);
    if (!(len == 8'd0 || int'(len) > MAXL)) begin
      foreach (pay[i]) send_byte(pay[i], maxgap);
      send_byte(cs, maxgap);
    end
    idle(4);
    chk({tag, ".nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s.byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, ".ok_pulses"}, 32'(ok_cnt), 32'(e_ok));
    chk({tag, ".err_pulses"}, 32'(err_cnt), 32'(e_err));
    chk({tag, ".err_code"}, 32'(err_code), 32'(e_code));
    if (e_err != 0) chk({tag, ".err_at_pulse"}, 32'(last_err), 32'(e_code));
    chk({tag, ".active_after"}, 32'(frame_active), 32'd0);
    chk({tag, ".out_valid_after"}, 32'(out_valid), 32'd0);
    chk({tag, ".both_pulses"}, 32'(both_seen), 32'd0);
  endtask

  initial begin
    int         t_last;
    int         waited;
    logic [7:0] win;
    logic       b;
    logic [7:0] len;
    logic [7:0] cs;
    int         r;

    // Reset state
    idle(3);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.frame_active", 32'(frame_active), 32'd0);
    chk("rst.frame_ok", 32'(frame_ok), 32'd0);
    chk("rst.frame_err", 32'(frame_err), 32'd0);
    chk("rst.err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // 1: good frame
    pq.delete();
    pq.push_back(8'h11); pq.push_back(8'h22); pq.push_back(8'h33);
    run_frame("t1", 8'h03, pq, 8'h03, 0);

    // 2: bad checksum
    run_frame("t2", 8'h03, pq, 8'h00, 1);

    // 3: illegal lengths
    pq.delete();
    run_frame("t3.len0", 8'h00, pq, 8'h00, 0);
    run_frame("t3.len33", 8'h21, pq, 8'h00, 0);
    chk("t3.active_seen", 32'(active_seen), 32'd1);

    // 4: sink stalled -> overflow on 2nd byte, first byte held
    clear_stats();
    out_ready = 1'b0;
    send_byte(8'hA7, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    idle(2);
    chk("t4.held_valid", 32'(out_valid), 32'd1);
    chk("t4.held_data", 32'(out_data), 32'h11);
    send_byte(8'h22, 0);
    idle(2);
    chk("t4.err_pulses", 32'(err_cnt), 32'd1);
    chk("t4.err_code", 32'(err_code), 32'd4);
    chk("t4.kept_data", 32'(out_data), 32'h11);
    chk("t4.kept_valid", 32'(out_valid), 32'd1);
    chk("t4.active", 32'(frame_active), 32'd0);
    out_ready = 1'b1;
    idle(3);
    chk("t4.drain_n", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t4.drain_byte", 32'(got_q[0]), 32'h11);
    chk("t4.drained_valid", 32'(out_valid), 32'd0);

    // 5: timeout exactly TMO cycles after the last strobe
    clear_stats();
    send_byte(8'hA7, 0);
    send_byte(8'h02, 0);
    t_last = cyc;
    @(negedge clk);
    chk("t5.active_before", 32'(frame_active), 32'd1);
    waited = 0;
    while (!frame_err && waited < 3 * TMO) begin
      @(negedge clk);
      waited++;
    end
    chk("t5.saw_err", 32'(frame_err), 32'd1);
    chk("t5.delay", 32'(cyc - t_last), 32'(TMO));
    chk("t5.err_code", 32'(err_code), 32'd3);
    chk("t5.active", 32'(frame_active), 32'd0);
    idle(2);

    // 6: reset mid-payload drops the pending byte, then a clean frame, then sync-free noise
    out_ready = 1'b0;
    send_byte(8'hA7, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
    rst_n = 1'b0;
    idle(2);
    chk("t6.rst_out_valid", 32'(out_valid), 32'd0);
    chk("t6.rst_out_data", 32'(out_data), 32'd0);
    chk("t6.rst_active", 32'(frame_active), 32'd0);
    chk("t6.rst_ok", 32'(frame_ok), 32'd0);
    chk("t6.rst_err", 32'(frame_err), 32'd0);
    chk("t6.rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);
    pq.delete();
    pq.push_back(8'h11); pq.push_back(8'h22); pq.push_back(8'h33);
    run_frame("t6.frame", 8'h03, pq, 8'h03, 1);
    clear_stats();
    win = 8'h00;
    for (int i = 0; i < 200; i++) begin
      b = 1'($urandom_range(1, 0));
      if ({win[6:0], b} == 8'hA7) b = ~b;
      win = {win[6:0], b};
      send_bit(b, 1);
    end
    idle(3);
    chk("t6.noise_active", 32'(active_seen), 32'd0);
    chk("t6.noise_err", 32'(err_cnt), 32'd0);
    chk("t6.noise_bytes", 32'(got_q.size()), 32'd0);

    // Randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      r = int'($urandom_range(9, 0));
      if (r == 0) len = 8'd0;
      else if (r == 1) len = 8'($urandom_range(255, MAXL + 1));
      else len = 8'($urandom_range(MAXL, 1));
      pq.delete();
      cs = len;
      if (r > 1) begin
        for (int i = 0; i < int'(len); i++) begin
          pq.push_back(8'($urandom_range(255, 0)));
          cs = cs ^ pq[i];
        end
        if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
      end
      run_frame($sformatf("rnd%0d", f), len, pq, cs, 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
